// File: rtl/player_sprite_ctrl.sv
// rtl/player_sprite_ctrl.sv - player sprite selection, animation/death tracking and ROM-aligned pixel output
module player_sprite_ctrl #(
    parameter int          SPR_W       = 48,
    parameter int          SPR_H       = 67,
    parameter int          ANIM_DIV    = 8,
    parameter int          DEAD_FRAMES = 60,
    parameter int          ROM_LAT     = 1,
    parameter logic [11:0] TRANSP_CLR  = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [9:0]  p0_x,
    input  logic [9:0]  p0_y,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [1:0]  p0_dir,
    input  logic [1:0]  p1_dir,
    input  logic        p0_moving,
    input  logic        p1_moving,
    input  logic        p0_dead,
    input  logic        p1_dead,
    input  logic [11:0] rom_clr,
    output logic        spr_players_no,
    output logic [3:0]  spr_state,
    output logic        spr_is_dead,
    output logic [5:0]  spr_x,
    output logic [6:0]  spr_y,
    output logic        pix_hit,
    output logic [11:0] pix_clr,
    output logic        p0_gone,
    output logic        p1_gone
);
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int DW = $clog2(DEAD_FRAMES + 1);
    localparam logic [9:0]    SPR_W10  = 10'(SPR_W);
    localparam logic [9:0]    SPR_H10  = 10'(SPR_H);
    localparam logic [AW-1:0] DIV_LAST = AW'(ANIM_DIV - 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEAD_FRAMES - 1);

    typedef enum logic [1:0] {ALIVE = 2'd0, DYING = 2'd1, GONE = 2'd2} life_t;

    life_t         life_q  [2];
    life_t         life_d  [2];
    logic [DW-1:0] dcnt_q  [2];
    logic [AW-1:0] div_q   [2];
    logic [1:0]    frame_q [2];
    logic [9:0]    px      [2];
    logic [9:0]    py      [2];
    logic [1:0]    dir     [2];
    logic [9:0]    dx      [2];
    logic [9:0]    dy      [2];
    logic [1:0]    moving, dead, hit, gone, dying;

    assign px     = '{p0_x, p1_x};
    assign py     = '{p0_y, p1_y};
    assign dir    = '{p0_dir, p1_dir};
    assign moving = {p1_moving, p0_moving};
    assign dead   = {p1_dead, p0_dead};

    // Life FSM: state register plus animation and death counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                life_q[i]  <= ALIVE;
                dcnt_q[i]  <= '0;
                div_q[i]   <= '0;
                frame_q[i] <= '0;
            end else begin
                life_q[i] <= life_d[i];
                case (life_q[i])
                    ALIVE: begin
                        // A tick landing on the death event neither animates nor counts
                        if (dead[i]) begin
                            dcnt_q[i] <= '0;
                        end else if (!moving[i]) begin
                            div_q[i]   <= '0;
                            frame_q[i] <= '0;
                        end else if (frame_tick) begin
                            if (div_q[i] == DIV_LAST) begin
                                div_q[i]   <= '0;
                                frame_q[i] <= frame_q[i] + 2'd1;
                            end else begin
                                div_q[i] <= div_q[i] + 1'b1;
                            end
                        end
                    end
                    DYING: if (frame_tick) dcnt_q[i] <= dcnt_q[i] + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            life_d[i] = life_q[i];
            case (life_q[i])
                ALIVE:   if (dead[i]) life_d[i] = DYING;
                DYING:   if (frame_tick && dcnt_q[i] == CNT_LAST) life_d[i] = GONE;
                default: life_d[i] = GONE;
            endcase
        end
    end

    always_comb begin
        gone  = '0;
        dying = '0;
        for (int i = 0; i < 2; i++) begin
            gone[i]  = (life_q[i] == GONE);
            dying[i] = (life_q[i] == DYING);
        end
    end

    assign p0_gone = gone[0];
    assign p1_gone = gone[1];

    // Negative offsets wrap to large unsigned values and fail the bound test
    always_comb begin
        hit = '0;
        for (int i = 0; i < 2; i++) begin
            dx[i]  = pix_x - px[i];
            dy[i]  = pix_y - py[i];
            hit[i] = (dx[i] < SPR_W10) && (dy[i] < SPR_H10) && !gone[i];
        end
    end

    logic               s1_valid;
    logic [ROM_LAT-1:0] vld_sr;
    logic               win;

    assign win = !hit[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            spr_players_no <= 1'b0;
            spr_state      <= '0;
            spr_is_dead    <= 1'b0;
            spr_x          <= '0;
            spr_y          <= '0;
            vld_sr         <= '0;
            pix_hit        <= 1'b0;
            pix_clr        <= '0;
        end else begin
            s1_valid <= |hit;
            if (|hit) begin
                spr_players_no <= win;
                spr_state      <= {dir[win], frame_q[win]};
                spr_is_dead    <= dying[win];
                spr_x          <= dx[win][5:0];
                spr_y          <= dy[win][6:0];
            end
            vld_sr[0] <= s1_valid;
            for (int i = 1; i < ROM_LAT; i++) vld_sr[i] <= vld_sr[i-1];
            pix_hit <= vld_sr[ROM_LAT-1] && (rom_clr != TRANSP_CLR);
            pix_clr <= (vld_sr[ROM_LAT-1] && (rom_clr != TRANSP_CLR)) ? rom_clr : 12'h000;
        end
    end
endmodule

// File: tb/tb_player_sprite_ctrl.sv
// tb/tb_player_sprite_ctrl.sv - directed bench for player_sprite_ctrl
module tb_player_sprite_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic [9:0]  p0_x = 10'd100, p0_y = 10'd50, p1_x = 10'd600, p1_y = 10'd400;
    logic [1:0]  p0_dir = 2'd2, p1_dir = 2'd1;
    logic        p0_moving = 1'b0, p1_moving = 1'b0, p0_dead = 1'b0, p1_dead = 1'b0;
    logic [11:0] rom_clr = 12'h123;
    logic        spr_players_no, spr_is_dead, pix_hit, p0_gone, p1_gone;
    logic [3:0]  spr_state;
    logic [5:0]  spr_x;
    logic [6:0]  spr_y;
    logic [11:0] pix_clr;
    int errors = 0;
    int checks = 0;

    player_sprite_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .pix_x(pix_x), .pix_y(pix_y),
        .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
        .p0_dir(p0_dir), .p1_dir(p1_dir),
        .p0_moving(p0_moving), .p1_moving(p1_moving),
        .p0_dead(p0_dead), .p1_dead(p1_dead),
        .rom_clr(rom_clr),
        .spr_players_no(spr_players_no), .spr_state(spr_state), .spr_is_dead(spr_is_dead),
        .spr_x(spr_x), .spr_y(spr_y),
        .pix_hit(pix_hit), .pix_clr(pix_clr),
        .p0_gone(p0_gone), .p1_gone(p1_gone)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ftick(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    // One pixel cycle; checks the stage-1 sprite request on the next edge
    task automatic probe_spr(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic exp_no, input logic [3:0] exp_state, input logic exp_dead);
        pix_x = x; pix_y = y;
        tick();
        chk({tag, "_no"}, 16'(spr_players_no), 16'(exp_no));
        chk({tag, "_state"}, 16'(spr_state), 16'(exp_state));
        chk({tag, "_dead"}, 16'(spr_is_dead), 16'(exp_dead));
        pix_x = 10'd0; pix_y = 10'd0;
        tick();
    endtask

    // One pixel cycle followed by the ROM return two cycles later and the output check
    task automatic probe_pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [11:0] rom, input logic exp_hit, input logic [11:0] exp_clr);
        pix_x = x; pix_y = y;
        rom_clr = 12'h000;
        tick();
        pix_x = 10'd0; pix_y = 10'd0;
        tick();
        chk({tag, "_early"}, 16'(pix_hit), 16'd0);
        rom_clr = rom;
        tick();
        chk({tag, "_hit"}, 16'(pix_hit), 16'(exp_hit));
        chk({tag, "_clr"}, 16'(pix_clr), 16'(exp_clr));
        rom_clr = 12'h000;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_hit", 16'(pix_hit), 16'd0);
        chk("rst_clr", 16'(pix_clr), 16'd0);
        chk("rst_state", 16'(spr_state), 16'd0);
        chk("rst_xy", 16'({spr_x, spr_y}), 16'd0);
        chk("rst_gone", 16'({p0_gone, p1_gone}), 16'd0);
        rst_n = 1'b1;
        tick();

        probe_spr("origin", 10'd100, 10'd50, 1'b0, 4'h8, 1'b0);
        pix_x = 10'd100; pix_y = 10'd50;
        tick();
        chk("origin_x", 16'(spr_x), 16'd0);
        chk("origin_y", 16'(spr_y), 16'd0);
        pix_x = 10'd147; pix_y = 10'd116;
        tick();
        chk("corner_x", 16'(spr_x), 16'd47);
        chk("corner_y", 16'(spr_y), 16'd66);
        pix_x = 10'd148; pix_y = 10'd50;
        tick();
        chk("hold_x", 16'(spr_x), 16'd47);
        pix_x = 10'd0; pix_y = 10'd0;
        tick();

        probe_pix("opaque", 10'd100, 10'd50, 12'h123, 1'b1, 12'h123);
        probe_pix("corner", 10'd147, 10'd116, 12'h456, 1'b1, 12'h456);
        probe_pix("right", 10'd148, 10'd50, 12'h123, 1'b0, 12'h000);
        probe_pix("bottom", 10'd100, 10'd117, 12'h123, 1'b0, 12'h000);
        probe_pix("left", 10'd99, 10'd50, 12'h123, 1'b0, 12'h000);
        probe_pix("transp", 10'd100, 10'd50, 12'hF0F, 1'b0, 12'h000);

        p0_moving = 1'b1;
        ftick(7);
        probe_spr("anim7", 10'd100, 10'd50, 1'b0, 4'h8, 1'b0);
        ftick(1);
        probe_spr("anim8", 10'd100, 10'd50, 1'b0, 4'h9, 1'b0);
        ftick(8);
        probe_spr("anim16", 10'd100, 10'd50, 1'b0, 4'hA, 1'b0);
        ftick(8);
        probe_spr("anim24", 10'd100, 10'd50, 1'b0, 4'hB, 1'b0);
        ftick(8);
        probe_spr("anim32", 10'd100, 10'd50, 1'b0, 4'h8, 1'b0);
        ftick(11);
        probe_spr("anim43", 10'd100, 10'd50, 1'b0, 4'h9, 1'b0);
        p0_moving = 1'b0;
        tick();
        probe_spr("stop", 10'd100, 10'd50, 1'b0, 4'h8, 1'b0);
        p0_moving = 1'b1;
        ftick(7);
        probe_spr("restart7", 10'd100, 10'd50, 1'b0, 4'h8, 1'b0);
        ftick(1);
        probe_spr("restart8", 10'd100, 10'd50, 1'b0, 4'h9, 1'b0);

        p0_x = 10'd200; p0_y = 10'd100; p1_x = 10'd200; p1_y = 10'd100;
        probe_spr("prio", 10'd210, 10'd110, 1'b0, 4'h9, 1'b0);

        // Death event coincides with a frame tick: not counted, frame frozen at 1
        p0_dead = 1'b1; frame_tick = 1'b1;
        tick();
        p0_dead = 1'b0; frame_tick = 1'b0;
        tick();
        probe_spr("dying0", 10'd210, 10'd110, 1'b0, 4'h9, 1'b1);
        ftick(59);
        chk("gone59", 16'(p0_gone), 16'd0);
        probe_spr("dying59", 10'd210, 10'd110, 1'b0, 4'h9, 1'b1);
        ftick(1);
        chk("gone60", 16'(p0_gone), 16'd1);
        chk("p1_alive", 16'(p1_gone), 16'd0);
        probe_spr("p1_wins", 10'd210, 10'd110, 1'b1, 4'h4, 1'b0);
        p1_x = 10'd600; p1_y = 10'd400;
        probe_pix("gone_pix", 10'd210, 10'd110, 12'h123, 1'b0, 12'h000);

        // Reset in the middle of a second death sequence
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        p0_moving = 1'b0;
        tick();
        p0_dead = 1'b1;
        tick();
        p0_dead = 1'b0;
        ftick(5);
        pix_x = 10'd210; pix_y = 10'd110; rom_clr = 12'h321;
        tick();
        tick();
        tick();
        chk("pre_rst_hit", 16'(pix_hit), 16'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_hit", 16'(pix_hit), 16'd0);
        chk("mrst_clr", 16'(pix_clr), 16'd0);
        chk("mrst_dead", 16'(spr_is_dead), 16'd0);
        chk("mrst_xy", 16'({spr_x, spr_y, spr_state}), 16'd0);
        tick();
        chk("post1_dead", 16'(spr_is_dead), 16'd0);
        chk("post1_hit", 16'(pix_hit), 16'd0);
        tick();
        chk("post2_hit", 16'(pix_hit), 16'd0);
        tick();
        chk("post3_hit", 16'(pix_hit), 16'd1);
        chk("post3_clr", 16'(pix_clr), 16'h321);
        chk("post3_gone", 16'(p0_gone), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
